tt_um_hoene_pwm_update_scheduler: RTL and testbench

Schedules when a newly decoded RGB word reaches the LED PWM generator. It sits between the protocol/serial-to-parallel stage and `tt_um_hoene_led_pwm`. It double-buffers the 30-bit colour word and commits it only at a PWM period boundary, so no partial or glitched PWM periods occur. A watchdog blanks the LED when the data stream stops.

---
 rtl/tt_um_hoene_smart_led_pkg.sv | 19 +
 rtl/tt_um_hoene_pwm_update_scheduler_if.sv | 23 ++
 rtl/tt_um_hoene_update_watchdog.sv | 23 ++
 rtl/tt_um_hoene_pwm_update_scheduler.sv | 67 ++++++
 tb/tb_tt_um_hoene_pwm_update_scheduler.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/tt_um_hoene_smart_led_pkg.sv
// tt_um_hoene_smart_led_pkg: shared colour-word layout, widths and scheduler state encoding
package tt_um_hoene_smart_led_pkg;
    localparam int COLOR_W   = 10;
    localparam int WORD_W    = 30;
    localparam int OVR_W     = 4;
    localparam int RED_MSB   = 29;
    localparam int RED_LSB   = 20;
    localparam int GREEN_MSB = 19;
    localparam int GREEN_LSB = 10;
    localparam int BLUE_MSB  = 9;
    localparam int BLUE_LSB  = 0;
    // bit 0 = pending, bit 1 = blanked
    typedef enum logic [1:0] {
        ST_EMPTY      = 2'b00,
        ST_PENDING    = 2'b01,
        ST_BLANKED    = 2'b10,
        ST_PEND_BLANK = 2'b11
    } sched_state_e;
endpackage

// File: rtl/tt_um_hoene_pwm_update_scheduler_if.sv
// tt_um_hoene_pwm_update_scheduler_if: decoded-word input and PWM-facing outputs of the scheduler
interface tt_um_hoene_pwm_update_scheduler_if;
    import tt_um_hoene_smart_led_pkg::*;
    logic               in_valid;
    logic [WORD_W-1:0]  in_data;
    logic               in_error;
    logic               pwm_period_end;
    logic [COLOR_W-1:0] data_red;
    logic [COLOR_W-1:0] data_green;
    logic [COLOR_W-1:0] data_blue;
    logic               update;
    logic               pending;
    logic               blanked;
    logic [OVR_W-1:0]   overrun_count;
    modport master (
        output in_valid, in_data, in_error, pwm_period_end,
        input  data_red, data_green, data_blue, update, pending, blanked, overrun_count
    );
    modport slave (
        input  in_valid, in_data, in_error, pwm_period_end,
        output data_red, data_green, data_blue, update, pending, blanked, overrun_count
    );
endinterface

// File: rtl/tt_um_hoene_update_watchdog.sv
// tt_um_hoene_update_watchdog: saturating idle counter; expired once WDT_CYCLES idle cycles pass (0 disables)
module tt_um_hoene_update_watchdog #(
    parameter int               WDT_W      = 20,
    parameter logic [WDT_W-1:0] WDT_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic expired
);
    localparam logic [WDT_W-1:0] ONE = 1;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    // count idle cycles, stop at the limit so expired stays asserted
    always_comb begin
        wdt_d = kick ? '0 : (wdt_q == WDT_CYCLES) ? wdt_q : wdt_q + ONE;
    end
    // counter register
    always_ff @(posedge clk) begin
        if (rst) wdt_q <= '0;
        else     wdt_q <= wdt_d;
    end
    assign expired = (WDT_CYCLES != '0) && (wdt_q == WDT_CYCLES);
endmodule

// File: rtl/tt_um_hoene_pwm_update_scheduler.sv
// tt_um_hoene_pwm_update_scheduler: double-buffers the colour word and commits it on PWM period boundaries
module tt_um_hoene_pwm_update_scheduler
    import tt_um_hoene_smart_led_pkg::*;
#(
    parameter int               WDT_W      = 20,
    parameter logic [WDT_W-1:0] WDT_CYCLES = 20'd1000000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    tt_um_hoene_pwm_update_scheduler_if.slave    bus
);
    localparam logic [OVR_W-1:0] OVR_ONE = 1;
    sched_state_e      state_q, state_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0] active_q, active_d;
    logic              update_q, update_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;
    logic              accept, commit, blank, expired, pend, blk, pend_n, blk_n;

    tt_um_hoene_update_watchdog #(.WDT_W(WDT_W), .WDT_CYCLES(WDT_CYCLES)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .kick    (accept),
        .expired (expired)
    );

    // next state: an error discards the pending word, so it also suppresses a commit in that cycle
    always_comb begin
        pend     = state_q[0];
        blk      = state_q[1];
        accept   = bus.in_valid & ~bus.in_error;
        commit   = bus.pwm_period_end & pend & ~bus.in_error;
        blank    = bus.pwm_period_end & ~pend & expired & ~blk;
        pend_n   = accept ? 1'b1 : (bus.in_error | commit) ? 1'b0 : pend;
        blk_n    = commit ? 1'b0 : blank ? 1'b1 : blk;
        state_d  = sched_state_e'({blk_n, pend_n});
        shadow_d = accept ? bus.in_data : shadow_q;
        active_d = commit ? shadow_q : blank ? '0 : active_q;
        update_d = commit | blank;
        ovr_d    = (accept & pend & ~commit & (ovr_q != '1)) ? ovr_q + OVR_ONE : ovr_q;
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BLANKED;
            shadow_q <= '0;
            active_q <= '0;
            update_q <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            update_q <= update_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.data_red      = active_q[RED_MSB:RED_LSB];
    assign bus.data_green    = active_q[GREEN_MSB:GREEN_LSB];
    assign bus.data_blue     = active_q[BLUE_MSB:BLUE_LSB];
    assign bus.update        = update_q;
    assign bus.pending       = state_q[0];
    assign bus.blanked       = state_q[1];
    assign bus.overrun_count = ovr_q;
endmodule

// File: tb/tb_tt_um_hoene_pwm_update_scheduler.sv
// tb_tt_um_hoene_pwm_update_scheduler: directed plan plus random traffic against a behavioural model
module tb_tt_um_hoene_pwm_update_scheduler;
    logic clk = 0;
    logic rst;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    tt_um_hoene_pwm_update_scheduler_if bus ();
    tt_um_hoene_pwm_update_scheduler_if bus0 ();

    tt_um_hoene_pwm_update_scheduler #(.WDT_W(20), .WDT_CYCLES(20'd100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    tt_um_hoene_pwm_update_scheduler #(.WDT_W(20), .WDT_CYCLES(20'd0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    typedef struct {
        logic [29:0] sh;
        logic [29:0] act;
        bit          pend;
        bit          blk;
        bit          upd;
        int          wdt;
        int          ovr;
    } mstate_t;

    mstate_t m0, m1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // one clock of the scheduler's rules, expressed as plain behaviour
    function automatic mstate_t mstep(mstate_t s, int lim, bit r, bit v, bit e, bit p, logic [29:0] d);
        mstate_t n;
        bit commit;
        n = s;
        n.upd = 0;
        commit = 0;
        if (r) begin
            n.sh = 0; n.act = 0; n.pend = 0; n.blk = 1; n.wdt = 0; n.ovr = 0;
            return n;
        end
        if (p && s.pend && !e) begin
            commit = 1;
            n.act = s.sh; n.pend = 0; n.blk = 0; n.upd = 1;
        end else if (p && !s.pend && lim != 0 && s.wdt == lim && !s.blk) begin
            n.act = 0; n.blk = 1; n.upd = 1;
        end
        if (e) n.pend = 0;
        if (v && !e) begin
            if (s.pend && !commit && s.ovr < 15) n.ovr = s.ovr + 1;
            n.sh = d; n.pend = 1; n.wdt = 0;
        end else begin
            n.wdt = (s.wdt < lim) ? s.wdt + 1 : lim;
        end
        return n;
    endfunction

    task automatic check_all();
        chk("a.red",   bus.data_red,       m0.act[29:20]);
        chk("a.green", bus.data_green,     m0.act[19:10]);
        chk("a.blue",  bus.data_blue,      m0.act[9:0]);
        chk("a.upd",   bus.update,         m0.upd);
        chk("a.pend",  bus.pending,        m0.pend);
        chk("a.blk",   bus.blanked,        m0.blk);
        chk("a.ovr",   bus.overrun_count,  m0.ovr);
        chk("z.red",   bus0.data_red,      m1.act[29:20]);
        chk("z.green", bus0.data_green,    m1.act[19:10]);
        chk("z.blue",  bus0.data_blue,     m1.act[9:0]);
        chk("z.upd",   bus0.update,        m1.upd);
        chk("z.pend",  bus0.pending,       m1.pend);
        chk("z.blk",   bus0.blanked,       m1.blk);
        chk("z.ovr",   bus0.overrun_count, m1.ovr);
    endtask

    task automatic step(input bit r, input bit v, input bit e, input bit p, input logic [29:0] d);
        rst = r;
        bus.in_valid = v;   bus0.in_valid = v;
        bus.in_error = e;   bus0.in_error = e;
        bus.pwm_period_end = p; bus0.pwm_period_end = p;
        bus.in_data = d;    bus0.in_data = d;
        @(posedge clk);
        m0 = mstep(m0, 100, r, v, e, p, d);
        m1 = mstep(m1, 0, r, v, e, p, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 30'h0);
    endtask

    initial begin
        logic [29:0] a, b, c, w;
        bit v, e, p, r;
        step(1, 0, 0, 0, 30'h0);
        step(1, 0, 0, 0, 30'h0);
        chk("rst_blk", bus.blanked, 1);
        chk("rst_red", bus.data_red, 0);
        idle(3);
        chk("idle_blk", bus.blanked, 1);
        step(0, 1, 0, 0, 30'h3FF80001);
        chk("acc_pend", bus.pending, 1);
        idle(4);
        step(0, 0, 0, 1, 30'h0);
        chk("c1_red", bus.data_red, 10'h3FF);
        chk("c1_green", bus.data_green, 10'h200);
        chk("c1_blue", bus.data_blue, 10'h001);
        chk("c1_upd", bus.update, 1);
        chk("c1_blk", bus.blanked, 0);
        idle(1);
        chk("c1_upd_off", bus.update, 0);
        for (int i = 0; i < 21; i++) begin
            a = 30'($urandom); b = 30'($urandom);
            step(0, 1, 0, 0, a);
            step(0, 1, 0, 0, b);
            step(0, 0, 0, 1, 30'h0);
            if (i == 0) chk("ovr_one", bus.overrun_count, 1);
        end
        chk("ovr_sat", bus.overrun_count, 15);
        chk("ovr_b", {bus.data_red, bus.data_green, bus.data_blue}, b);
        step(1, 0, 0, 0, 30'h0);
        b = 30'h12345678; c = 30'h0ABCDEF1;
        step(0, 1, 0, 0, b);
        step(0, 1, 0, 1, c);
        chk("sim_act", {bus.data_red, bus.data_green, bus.data_blue}, b);
        chk("sim_pend", bus.pending, 1);
        chk("sim_ovr", bus.overrun_count, 0);
        step(0, 0, 0, 1, 30'h0);
        chk("sim_c", {bus.data_red, bus.data_green, bus.data_blue}, c);
        step(0, 1, 0, 0, 30'h3FFFFFFF);
        step(0, 0, 1, 0, 30'h0);
        step(0, 0, 0, 1, 30'h0);
        chk("err_act", {bus.data_red, bus.data_green, bus.data_blue}, c);
        chk("err_pend", bus.pending, 0);
        chk("err_upd", bus.update, 0);
        idle(110);
        step(0, 0, 0, 1, 30'h0);
        chk("wdt_red", bus.data_red, 0);
        chk("wdt_blk", bus.blanked, 1);
        chk("wdt_upd", bus.update, 1);
        chk("wdt0_blk", bus0.blanked, 0);
        chk("wdt0_act", {bus0.data_red, bus0.data_green, bus0.data_blue}, c);
        w = 30'h2468ACE0;
        step(0, 1, 0, 0, w);
        step(0, 0, 0, 1, 30'h0);
        chk("wdt_rest", {bus.data_red, bus.data_green, bus.data_blue}, w);
        chk("wdt_rest_blk", bus.blanked, 0);
        step(0, 1, 0, 0, 30'h1);
        step(0, 1, 0, 0, 30'h2);
        step(1, 0, 0, 0, 30'h0);
        chk("mrst_pend", bus.pending, 0);
        chk("mrst_data", {bus.data_red, bus.data_green, bus.data_blue}, 0);
        chk("mrst_blk", bus.blanked, 1);
        chk("mrst_ovr", bus.overrun_count, 0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            if ((i % 500) >= 350) begin
                v = 0; e = 0;
            end else begin
                v = ($urandom_range(0, 3) == 0);
                e = ($urandom_range(0, 15) == 0);
            end
            p = !e && ($urandom_range(0, 7) == 0);
            step(r, v, e, p, 30'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
